fetch_stage: RTL and testbench

- First pipeline stage of the 16-bit RISC core; produces the instruction stream that the decode stage consumes.
- Owns the PC, drives the instruction-memory read address, and assembles one-word and two-word (opcode + immediate) instructions.
- Emits each complete instruction with its PC into the IF/ID boundary with a valid flag, honouring stall and flush from later stages.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/pc_reg.sv | 21 ++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage of the 16-bit RISC core.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_IMM = 2'd1,
      RESET_VEC = 2'd2
   } fetch_state_t;

   // Opcode prefix marking a two-word (opcode + immediate) instruction
   localparam logic [1:0]  IMM_PREFIX    = 2'b11;
   localparam int          IMM_PREFIX_HI = 15;
   localparam int          IMM_PREFIX_LO = 14;

   // Encoding driven onto the instruction bus for bubbles
   localparam logic [15:0] NOP = 16'h0000;

   function automatic logic is_two_word(input logic [15:0] word);
      return word[IMM_PREFIX_HI:IMM_PREFIX_LO] == IMM_PREFIX;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset, load, increment or hold.
module pc_reg #(
   parameter int              PC_W     = 20,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            inc,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   // Load beats increment; increment wraps modulo 2^PC_W
   always_ff @(posedge clk) begin
      if (rst)       pc <= RESET_PC;
      else if (load) pc <= load_val;
      else if (inc)  pc <= pc + PC_W'(1);
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, assembles one- and two-word
// instructions and presents them to decode with a valid flag.
// Optional feature macro: FETCH_RESET_VECTOR_EN (PC loaded from imem[0]
// on the first cycle out of reset).
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              PC_W     = 20,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   input  logic            stall,
   input  logic            flush,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            if_valid,
   output logic [15:0]     if_instr,
   output logic [15:0]     if_imm,
   output logic [PC_W-1:0] if_pc,
   output logic [PC_W-1:0] if_pc_next
);

   fetch_state_t    state;
   logic [15:0]     hold_reg;
   logic [PC_W-1:0] hold_pc;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus1;
   logic            in_vec;
   logic            pc_load;
   logic            pc_inc;
   logic [PC_W-1:0] pc_load_val;

`ifdef FETCH_RESET_VECTOR_EN
   localparam fetch_state_t RESET_STATE = RESET_VEC;
   assign in_vec = (state == RESET_VEC);
`else
   localparam fetch_state_t RESET_STATE = FETCH_OP;
   assign in_vec = 1'b0;
`endif

   assign pc_plus1  = pc + PC_W'(1);
   // While fetching the reset vector the memory is read at word 0
   assign imem_addr = in_vec ? '0 : pc;

   // Next-PC selection: redirect, reset vector, or sequential advance.
   // The reset vector state ignores stall, so it always loads.
   assign pc_load     = flush | in_vec;
   assign pc_load_val = flush ? redirect_pc : PC_W'(imem_data);
   assign pc_inc      = ~stall;

   pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load     (pc_load),
      .inc      (pc_inc),
      .load_val (pc_load_val),
      .pc       (pc)
   );

   // Fetch FSM and IF/ID output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RESET_STATE;
         hold_reg   <= NOP;
         hold_pc    <= '0;
         if_valid   <= 1'b0;
         if_instr   <= NOP;
         if_imm     <= NOP;
         if_pc      <= '0;
         if_pc_next <= '0;
      end else if (flush) begin
         // Any half-fetched two-word instruction is dropped here
         state    <= FETCH_OP;
         if_valid <= 1'b0;
         if_instr <= NOP;
         if_imm   <= NOP;
      end else if (!stall || in_vec) begin
         case (state)
            FETCH_OP: begin
               if (is_two_word(imem_data)) begin
                  hold_reg <= imem_data;
                  hold_pc  <= pc;
                  if_valid <= 1'b0;
                  state    <= FETCH_IMM;
               end else begin
                  if_instr   <= imem_data;
                  if_imm     <= NOP;
                  if_pc      <= pc;
                  if_pc_next <= pc_plus1;
                  if_valid   <= 1'b1;
               end
            end
            FETCH_IMM: begin
               if_instr   <= hold_reg;
               if_imm     <= imem_data;
               if_pc      <= hold_pc;
               if_pc_next <= pc_plus1;
               if_valid   <= 1'b1;
               state      <= FETCH_OP;
            end
            default: begin
               // RESET_VEC: PC is being loaded from the vector word
               if_valid <= 1'b0;
               state    <= FETCH_OP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

   localparam int PC_W = 20;

`ifdef FETCH_RESET_VECTOR_EN
   localparam logic [PC_W-1:0] BASE = 20'h00100;
   localparam logic [15:0]     W0   = 16'h0100;
`else
   localparam logic [PC_W-1:0] BASE = 20'h00000;
   localparam logic [15:0]     W0   = 16'h1111;
`endif

   logic            clk = 1'b0;
   logic            rst, stall, flush;
   logic [PC_W-1:0] imem_addr, redirect_pc;
   logic [15:0]     imem_data;
   logic            if_valid;
   logic [15:0]     if_instr, if_imm;
   logic [PC_W-1:0] if_pc, if_pc_next;

   logic [15:0] mem [0:1023];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[9:0]];

   fetch_stage #(.PC_W(PC_W), .RESET_PC(20'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_imm      (if_imm),
      .if_pc       (if_pc),
      .if_pc_next  (if_pc_next)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_valid(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                            input logic [PC_W-1:0] pc, input logic [PC_W-1:0] nxt,
                            input logic [PC_W-1:0] addr);
      chk({tag, ".valid"}, 32'(if_valid), 32'd1);
      chk({tag, ".instr"}, 32'(if_instr), 32'(ins));
      chk({tag, ".imm"},   32'(if_imm),   32'(imm));
      chk({tag, ".pc"},    32'(if_pc),    32'(pc));
      chk({tag, ".next"},  32'(if_pc_next), 32'(nxt));
      chk({tag, ".addr"},  32'(imem_addr), 32'(addr));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[0] = W0;
      mem[BASE[9:0] + 0]  = 16'h1111;
      mem[BASE[9:0] + 1]  = 16'h2222;
      mem[BASE[9:0] + 2]  = 16'h3333;
      mem[BASE[9:0] + 3]  = 16'h4444;
      mem[BASE[9:0] + 4]  = 16'hC123;
      mem[BASE[9:0] + 5]  = 16'hBEEF;
      mem[BASE[9:0] + 6]  = 16'h5555;
      mem[BASE[9:0] + 7]  = 16'h7777;
      mem[BASE[9:0] + 8]  = 16'h8888;
      mem[BASE[9:0] + 9]  = 16'hD000;
      mem[BASE[9:0] + 10] = 16'h0A0A;
      mem[10'h040] = 16'h4040;
      mem[10'h041] = 16'h4141;
      mem[10'h3FF] = 16'h0ABC;

      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
      step();
      step();
      // reset state
      chk("rst.valid", 32'(if_valid), 32'd0);
      chk("rst.instr", 32'(if_instr), 32'd0);
      chk("rst.imm",   32'(if_imm),   32'd0);
      chk("rst.pc",    32'(if_pc),    32'd0);
      chk("rst.addr",  32'(imem_addr), 32'd0);
      rst = 1'b0;

`ifdef FETCH_RESET_VECTOR_EN
      step();
      chk("vec.valid", 32'(if_valid), 32'd0);
      chk("vec.addr",  32'(imem_addr), 32'h00100);
`endif

      // sequential one-word fetch
      step(); chk_valid("seq0", 16'h1111, 16'h0, BASE + 0, BASE + 1, BASE + 1);
      step(); chk_valid("seq1", 16'h2222, 16'h0, BASE + 1, BASE + 2, BASE + 2);
      step(); chk_valid("seq2", 16'h3333, 16'h0, BASE + 2, BASE + 3, BASE + 3);
      step(); chk_valid("seq3", 16'h4444, 16'h0, BASE + 3, BASE + 4, BASE + 4);

      // two-word: one bubble, then opcode+immediate
      step();
      chk("two.bubble", 32'(if_valid), 32'd0);
      chk("two.addr",   32'(imem_addr), 32'(BASE + 5));
      step(); chk_valid("two", 16'hC123, 16'hBEEF, BASE + 4, BASE + 6, BASE + 6);
      step(); chk_valid("seq6", 16'h5555, 16'h0, BASE + 6, BASE + 7, BASE + 7);

      // stall three cycles at PC=7
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_valid("stall", 16'h5555, 16'h0, BASE + 6, BASE + 7, BASE + 7);
      end
      stall = 1'b0;
      step(); chk_valid("resume7", 16'h7777, 16'h0, BASE + 7, BASE + 8, BASE + 8);
      step(); chk_valid("seq8",    16'h8888, 16'h0, BASE + 8, BASE + 9, BASE + 9);

      // start two-word at 9, then flush+stall during FETCH_IMM
      step();
      chk("d0.bubble", 32'(if_valid), 32'd0);
      chk("d0.addr",   32'(imem_addr), 32'(BASE + 10));
      flush = 1'b1; stall = 1'b1; redirect_pc = 20'h00040;
      step();
      chk("flush.valid", 32'(if_valid), 32'd0);
      chk("flush.instr", 32'(if_instr), 32'd0);
      chk("flush.imm",   32'(if_imm),   32'd0);
      chk("flush.addr",  32'(imem_addr), 32'h00040);
      flush = 1'b0; stall = 1'b0;
      step(); chk_valid("redir", 16'h4040, 16'h0, 20'h00040, 20'h00041, 20'h00041);

      // wrap at all-ones
      flush = 1'b1; redirect_pc = 20'hFFFFF;
      step();
      chk("wflush.valid", 32'(if_valid), 32'd0);
      chk("wflush.addr",  32'(imem_addr), 32'hFFFFF);
      flush = 1'b0;
      step(); chk_valid("wrap", 16'h0ABC, 16'h0, 20'hFFFFF, 20'h00000, 20'h00000);
      step(); chk_valid("wrap0", W0, 16'h0, 20'h00000, 20'h00001, 20'h00001);

      // reset in the middle of a two-word fetch
      flush = 1'b1; redirect_pc = BASE + 4;
      step();
      flush = 1'b0;
      step();
      chk("mid.bubble", 32'(if_valid), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid.rst.valid", 32'(if_valid), 32'd0);
      chk("mid.rst.addr",  32'(imem_addr), 32'd0);
`ifdef FETCH_RESET_VECTOR_EN
      step();
      chk("mid.vec.valid", 32'(if_valid), 32'd0);
`endif
      step(); chk_valid("mid.after", 16'h1111, 16'h0, BASE + 0, BASE + 1, BASE + 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
